// File: rtl/seq_ctrl_if.sv
// Sequencer <-> datapath/memory signal bundle. The sequencer uses the master
// modport; the datapath side uses slave.
interface seq_ctrl_if #(
  parameter int CNT_W = 16
);
  logic             run;
  logic [15:0]      opCode;
  logic             BR;
  logic             mem_ack;
  logic             pc_en;
  logic             pc_sel;
  logic             a_we;
  logic             b_we;
  logic             znc_we;
  logic             mem_req;
  logic             WE;
  logic             halted;
  logic             err;
  logic [2:0]       state;
  logic [CNT_W-1:0] icount;

  modport master (
    input  run, opCode, BR, mem_ack,
    output pc_en, pc_sel, a_we, b_we, znc_we, mem_req, WE,
           halted, err, state, icount
  );

  modport slave (
    output run, opCode, BR, mem_ack,
    input  pc_en, pc_sel, a_we, b_we, znc_we, mem_req, WE,
           halted, err, state, icount
  );
endinterface

// File: rtl/seq_ctrl.sv
// Multi-cycle sequencer for the A/B/ZNC accumulator datapath with bounded memory wait.
// Optional SEQ_CTRL_SINGLE_STEP_EN adds a step input for single-instruction execution.
module seq_ctrl #(
  parameter int MEM_TIMEOUT = 15,
  parameter int CNT_W       = 16
) (
  input  logic       clk,
  input  logic       rst,
`ifdef SEQ_CTRL_SINGLE_STEP_EN
  input  logic       step,
`endif
  seq_ctrl_if.master bus
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_EXEC  = 3'd2,
    S_MEM   = 3'd3,
    S_WB    = 3'd4,
    S_HALT  = 3'd5
  } state_e;

  state_e           state_q, state_d;
  logic [3:0]       cls_q, cls_d;
  logic [7:0]       wait_q, wait_d;
  logic [CNT_W-1:0] icount_q, icount_d;
  logic             err_q, err_d;
  logic             step_mode_q, step_mode_d;
  logic             pc_en_q, a_we_q, b_we_q, znc_we_q, mem_req_q, we_q, halted_q;
  logic             wb_d;

  always_comb begin
    state_d     = state_q;
    cls_d       = cls_q;
    wait_d      = wait_q;
    icount_d    = icount_q;
    err_d       = err_q;
    step_mode_d = step_mode_q;
    case (state_q)
      S_IDLE: begin
        if (bus.run) begin
          state_d     = S_FETCH;
          step_mode_d = 1'b0;
        end
`ifdef SEQ_CTRL_SINGLE_STEP_EN
        else if (step) begin
          state_d     = S_FETCH;
          step_mode_d = 1'b1;
        end
`endif
      end
      S_FETCH: begin
        state_d = S_EXEC;
        cls_d   = bus.opCode[15:12];
      end
      S_EXEC: begin
        if (cls_q == 4'hF) begin
          state_d = S_HALT;
        end else if (cls_q == 4'hD || cls_q == 4'hE) begin
          state_d = S_MEM;
          wait_d  = 8'd0;
        end else begin
          state_d = S_WB;
        end
      end
      S_MEM: begin
        // An ack in the final allowed cycle still completes the access.
        if (bus.mem_ack) begin
          state_d = S_WB;
        end else begin
          wait_d = wait_q + 8'd1;
          if (wait_q + 8'd1 == 8'(MEM_TIMEOUT)) begin
            state_d = S_HALT;
            err_d   = 1'b1;
          end
        end
      end
      S_WB: begin
        icount_d    = icount_q + 1'b1;
        state_d     = (bus.run && !step_mode_q) ? S_FETCH : S_IDLE;
        step_mode_d = 1'b0;
      end
      S_HALT:  state_d = S_HALT;
      default: state_d = S_IDLE;
    endcase
  end

  // Strobes are registered from the next state so they line up with state_q.
  assign wb_d = (state_d == S_WB);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cls_q       <= 4'd0;
      wait_q      <= 8'd0;
      icount_q    <= '0;
      err_q       <= 1'b0;
      step_mode_q <= 1'b0;
      pc_en_q     <= 1'b0;
      a_we_q      <= 1'b0;
      b_we_q      <= 1'b0;
      znc_we_q    <= 1'b0;
      mem_req_q   <= 1'b0;
      we_q        <= 1'b0;
      halted_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      cls_q       <= cls_d;
      wait_q      <= wait_d;
      icount_q    <= icount_d;
      err_q       <= err_d;
      step_mode_q <= step_mode_d;
      pc_en_q     <= wb_d;
      a_we_q      <= wb_d && (cls_d <= 4'h7 || cls_d == 4'hD);
      b_we_q      <= wb_d && (cls_d >= 4'h8 && cls_d <= 4'hB);
      znc_we_q    <= wb_d && (cls_d <= 4'hB);
      mem_req_q   <= (state_d == S_MEM);
      we_q        <= (state_d == S_MEM) && (cls_d == 4'hE);
      halted_q    <= (state_d == S_HALT);
    end
  end

  assign bus.pc_en   = pc_en_q;
  assign bus.pc_sel  = pc_en_q & bus.BR;
  assign bus.a_we    = a_we_q;
  assign bus.b_we    = b_we_q;
  assign bus.znc_we  = znc_we_q;
  assign bus.mem_req = mem_req_q;
  assign bus.WE      = we_q;
  assign bus.halted  = halted_q;
  assign bus.err     = err_q;
  assign bus.state   = state_q;
  assign bus.icount  = icount_q;

endmodule
